// File: rtl/s_axi_interface.sv
// AXI4-Lite slave exposing a pixel store, a new-image control flag and the
// coprocessor's inference result to software.
module s_axi_interface #(
    parameter int unsigned AXI_DATA_WIDTH  = 32,
    parameter int unsigned AXI_ADDR_WIDTH  = 32,
    parameter int unsigned IMAGE_SIZE      = 256,
    parameter int unsigned IMAGE_SIZE_BITS = 8,
    parameter int unsigned PIXEL_MAX_VALUE = 255,
    parameter int unsigned PIXEL_BITS      = 8
) (
    input  logic                        ACLK,
    input  logic                        ARESETN,
    input  logic [AXI_ADDR_WIDTH-1:0]   AWADDR,
    input  logic [2:0]                  AWPROT,
    input  logic                        AWVALID,
    output logic                        AWREADY,
    input  logic [AXI_DATA_WIDTH-1:0]   WDATA,
    input  logic [AXI_DATA_WIDTH/8-1:0] WSTRB,
    input  logic                        WVALID,
    output logic                        WREADY,
    output logic [1:0]                  BRESP,
    output logic                        BVALID,
    input  logic                        BREADY,
    input  logic [AXI_ADDR_WIDTH-1:0]   ARADDR,
    input  logic [2:0]                  ARPROT,
    input  logic                        ARVALID,
    output logic                        ARREADY,
    output logic [AXI_DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]                  RRESP,
    output logic                        RVALID,
    input  logic                        RREADY,
    input  logic                        COPROCESSOR_RDY,
    input  logic [7:0]                  INFERED_DIGIT,
    output logic [PIXEL_BITS-1:0]       IMAGE [IMAGE_SIZE],
    output logic                        NEW_IMAGE
);

    logic [PIXEL_BITS-1:0]     image_data_q [IMAGE_SIZE];
    logic [PIXEL_BITS-1:0]     image_data_d [IMAGE_SIZE];
    logic                      new_image_q, new_image_d;
    logic                      awready_q, awready_d;
    logic                      bvalid_q, bvalid_d;
    logic                      arready_q, arready_d;
    logic                      rvalid_q, rvalid_d;
    logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [AXI_DATA_WIDTH-1:0] rd_word;
    logic                      wr_go, rd_go;

    // One write in flight at a time: the ready pulse and a pending response both block.
    assign wr_go = AWVALID && WVALID && !bvalid_q && !awready_q;
    assign rd_go = ARVALID && !rvalid_q && !arready_q;

    always_comb begin
        image_data_d = image_data_q;
        new_image_d  = new_image_q;
        if (wr_go && WSTRB[0]) begin
            if (AWADDR < AXI_ADDR_WIDTH'(IMAGE_SIZE)) begin
                image_data_d[AWADDR[IMAGE_SIZE_BITS-1:0]] = WDATA[PIXEL_BITS-1:0];
            end else if (AWADDR == AXI_ADDR_WIDTH'(IMAGE_SIZE)) begin
                new_image_d = WDATA[0];
            end
        end
    end

    always_comb begin
        awready_d = wr_go;
        bvalid_d  = bvalid_q;
        if (awready_q) begin
            bvalid_d = 1'b1;
        end else if (bvalid_q && BREADY) begin
            bvalid_d = 1'b0;
        end
    end

    // Address 0 is the status word, so pixel 0 is write-only from software.
    always_comb begin
        rd_word = '0;
        if (ARADDR == '0) begin
            rd_word[31]  = COPROCESSOR_RDY;
            rd_word[7:0] = INFERED_DIGIT;
        end else if (ARADDR < AXI_ADDR_WIDTH'(IMAGE_SIZE)) begin
            rd_word[PIXEL_BITS-1:0] = image_data_q[ARADDR[IMAGE_SIZE_BITS-1:0]];
        end else if (ARADDR == AXI_ADDR_WIDTH'(IMAGE_SIZE)) begin
            rd_word[0] = new_image_q;
        end
    end

    always_comb begin
        arready_d = rd_go;
        rdata_d   = rd_go ? rd_word : rdata_q;
        rvalid_d  = rvalid_q;
        if (arready_q) begin
            rvalid_d = 1'b1;
        end else if (rvalid_q && RREADY) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int unsigned i = 0; i < IMAGE_SIZE; i++) begin
                image_data_q[i] <= '0;
            end
            new_image_q <= 1'b0;
            awready_q   <= 1'b0;
            bvalid_q    <= 1'b0;
            arready_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
        end else begin
            image_data_q <= image_data_d;
            new_image_q  <= new_image_d;
            awready_q    <= awready_d;
            bvalid_q     <= bvalid_d;
            arready_q    <= arready_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
        end
    end

    assign AWREADY   = awready_q;
    assign WREADY    = awready_q;
    assign BVALID    = bvalid_q;
    assign BRESP     = 2'b00;
    assign ARREADY   = arready_q;
    assign RVALID    = rvalid_q;
    assign RDATA     = rdata_q;
    assign RRESP     = 2'b00;
    assign IMAGE     = image_data_q;
    assign NEW_IMAGE = new_image_q;

    logic unused_ok;
    assign unused_ok = ^{AWPROT, ARPROT, WSTRB[AXI_DATA_WIDTH/8-1:1],
                         WDATA[AXI_DATA_WIDTH-1:PIXEL_BITS], (PIXEL_MAX_VALUE != 0)};

endmodule

// File: tb/tb_s_axi_interface.sv
// Scoreboard bench for s_axi_interface: tasks drive AXI-Lite traffic and queue expected
// responses from an array model; a negedge monitor pops and compares B/R beats.
module tb_s_axi_interface;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic [2:0]  AWPROT, ARPROT;
    logic [3:0]  WSTRB;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [1:0]  BRESP, RRESP;
    logic        COPROCESSOR_RDY, NEW_IMAGE;
    logic [7:0]  INFERED_DIGIT;
    logic [7:0]  IMAGE [256];

    s_axi_interface dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .COPROCESSOR_RDY(COPROCESSOR_RDY), .INFERED_DIGIT(INFERED_DIGIT),
        .IMAGE(IMAGE), .NEW_IMAGE(NEW_IMAGE)
    );

    always #5 ACLK = ~ACLK;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  model_img [256];
    logic        model_new;
    logic [1:0]  bq [$];
    logic [31:0] rq [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out, got no handshake expected one", name);
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    function automatic logic [31:0] exp_read(input int addr);
        if (addr == 0) return {COPROCESSOR_RDY, 23'd0, INFERED_DIGIT};
        if (addr < 256) return {24'd0, model_img[addr]};
        if (addr == 256) return {31'd0, model_new};
        return 32'd0;
    endfunction

    task automatic model_write(input int addr, input logic [31:0] data, input logic [3:0] strb);
        if (strb[0] && addr < 256) model_img[addr] = data[7:0];
        else if (strb[0] && addr == 256) model_new = data[0];
    endtask

    task automatic check_image(input string name);
        for (int i = 0; i < 256; i++) check(name, {24'd0, IMAGE[i]}, {24'd0, model_img[i]});
    endtask

    // Monitor: a beat is taken when valid and ready are both high ahead of the next edge.
    always @(negedge ACLK) begin
        if (ARESETN) begin
            if (BVALID && BREADY) begin
                if (bq.size() == 0) check("b_unexpected", 32'(BVALID), 32'd0);
                else check("bresp", 32'(BRESP), 32'(bq.pop_front()));
            end
            if (RVALID && RREADY) begin
                if (rq.size() == 0) check("r_unexpected", 32'(RVALID), 32'd0);
                else begin
                    check("rresp", 32'(RRESP), 32'd0);
                    check("rdata", RDATA, rq.pop_front());
                end
            end
        end
    end

    task automatic axi_write(input int addr, input logic [31:0] data, input logic [3:0] strb);
        int cyc;
        tick();
        AWADDR = 32'(addr); WDATA = data; WSTRB = strb; AWVALID = 1; WVALID = 1; BREADY = 0;
        cyc = 0;
        while (!(AWREADY && WREADY) && cyc < 40) begin tick(); cyc++; end
        AWVALID = 0; WVALID = 0;
        if (cyc >= 40) begin timeout("aw_handshake"); return; end
        model_write(addr, data, strb);
        bq.push_back(2'b00);
        cyc = 0;
        while (!BVALID && cyc < 40) begin tick(); cyc++; end
        repeat ($urandom_range(0, 3)) tick();
        BREADY = 1;
        cyc = 0;
        while (bq.size() != 0 && cyc < 40) begin tick(); cyc++; end
        if (cyc >= 40) begin timeout("b_response"); bq.delete(); end
    endtask

    task automatic axi_read(input int addr);
        int cyc;
        tick();
        ARADDR = 32'(addr); ARVALID = 1; RREADY = 0;
        cyc = 0;
        while (!ARREADY && cyc < 40) begin tick(); cyc++; end
        ARVALID = 0;
        if (cyc >= 40) begin timeout("ar_handshake"); return; end
        rq.push_back(exp_read(addr));
        cyc = 0;
        while (!RVALID && cyc < 40) begin tick(); cyc++; end
        repeat ($urandom_range(0, 3)) tick();
        RREADY = 1;
        cyc = 0;
        while (rq.size() != 0 && cyc < 40) begin tick(); cyc++; end
        if (cyc >= 40) begin timeout("r_response"); rq.delete(); end
    endtask

    initial begin
        int cyc;
        logic [31:0] d;
        ARESETN = 0; AWADDR = 0; AWPROT = 0; AWVALID = 0; WDATA = 0; WSTRB = 0; WVALID = 0;
        BREADY = 0; ARADDR = 0; ARPROT = 0; ARVALID = 0; RREADY = 0;
        COPROCESSOR_RDY = 0; INFERED_DIGIT = 0;
        for (int i = 0; i < 256; i++) model_img[i] = 8'd0;
        model_new = 0;
        repeat (3) @(negedge ACLK);
        check("reset_ctrl", 32'({AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP}), 32'd0);
        check("reset_rdata", RDATA, 32'd0);
        check("reset_new_image", 32'(NEW_IMAGE), 32'd0);
        check_image("reset_image");
        @(posedge ACLK); #1; ARESETN = 1;

        // Full image load with a couple of known MNIST-like pixels.
        for (int i = 0; i < 256; i++) begin
            d = (i == 56) ? 32'd3 : (i == 71) ? 32'd174 : 32'($urandom_range(0, 255));
            axi_write(i, d, 4'h1);
        end
        check_image("image_load");
        check("pixel_71", {24'd0, IMAGE[71]}, 32'd174);
        axi_read(56);
        axi_read(71);

        axi_write(256, 32'd1, 4'h1);
        check("new_image_set", 32'(NEW_IMAGE), 32'd1);
        axi_read(256);
        axi_write(256, 32'd0, 4'h1);
        check("new_image_clr", 32'(NEW_IMAGE), 32'd0);

        INFERED_DIGIT = 8'd7;
        axi_read(0);
        COPROCESSOR_RDY = 1; INFERED_DIGIT = 8'd5;
        axi_read(0);
        check("status_word", exp_read(0), 32'h8000_0005);

        axi_write(10, 32'hFF, 4'h0);
        axi_read(10);
        axi_write(300, 32'h1, 4'hF);
        axi_read(300);
        check_image("no_strobe_image");

        // Stalled write response with a second write waiting behind it.
        tick();
        AWADDR = 40; WDATA = 32'h99; WSTRB = 4'h1; AWVALID = 1; WVALID = 1; BREADY = 0;
        cyc = 0;
        while (!AWREADY && cyc < 40) begin tick(); cyc++; end
        if (cyc >= 40) timeout("stall_aw");
        model_img[40] = 8'h99;
        bq.push_back(2'b00);
        AWADDR = 41; WDATA = 32'h77;
        cyc = 0;
        while (!BVALID && cyc < 40) begin tick(); cyc++; end
        for (int k = 0; k < 5; k++) begin
            tick();
            check("b_stall_valid", 32'(BVALID), 32'd1);
            check("b_stall_no_aw", 32'(AWREADY), 32'd0);
        end
        AWVALID = 0; WVALID = 0; BREADY = 1;
        cyc = 0;
        while (bq.size() != 0 && cyc < 40) begin tick(); cyc++; end
        if (cyc >= 40) begin timeout("stall_b"); bq.delete(); end
        check("stall_no_second_write", {24'd0, IMAGE[41]}, {24'd0, model_img[41]});

        // Stalled read response with a second read waiting behind it.
        tick();
        ARADDR = 40; ARVALID = 1; RREADY = 0;
        cyc = 0;
        while (!ARREADY && cyc < 40) begin tick(); cyc++; end
        if (cyc >= 40) timeout("stall_ar");
        rq.push_back(32'h99);
        ARADDR = 0;
        cyc = 0;
        while (!RVALID && cyc < 40) begin tick(); cyc++; end
        for (int k = 0; k < 5; k++) begin
            tick();
            check("r_stall_valid", 32'(RVALID), 32'd1);
            check("r_stall_no_ar", 32'(ARREADY), 32'd0);
            check("r_stall_data", RDATA, 32'h99);
        end
        ARVALID = 0; RREADY = 1;
        cyc = 0;
        while (rq.size() != 0 && cyc < 40) begin tick(); cyc++; end
        if (cyc >= 40) begin timeout("stall_r"); rq.delete(); end

        fork
            axi_write(5, 32'hA5, 4'h1);
            axi_read(6);
        join

        COPROCESSOR_RDY = 1'($urandom_range(0, 1));
        INFERED_DIGIT = 8'($urandom_range(0, 9));
        for (int k = 0; k < 300; k++) begin
            int a;
            a = ($urandom_range(0, 9) == 0) ? 256 : int'($urandom_range(0, 300));
            if ($urandom_range(0, 1) == 1) axi_write(a, $urandom, 4'($urandom_range(0, 15)));
            else axi_read(a);
        end
        check_image("random_image");
        check("random_new_image", 32'(NEW_IMAGE), 32'(model_new));

        // Reset while a write response is outstanding.
        axi_write(256, 32'd1, 4'h1);
        tick();
        AWADDR = 20; WDATA = 32'h55; WSTRB = 4'h1; AWVALID = 1; WVALID = 1; BREADY = 0;
        cyc = 0;
        while (!AWREADY && cyc < 40) begin tick(); cyc++; end
        AWVALID = 0; WVALID = 0;
        cyc = 0;
        while (!BVALID && cyc < 40) begin tick(); cyc++; end
        check("pre_reset_bvalid", 32'(BVALID), 32'd1);
        #2 ARESETN = 0;
        #1;
        for (int i = 0; i < 256; i++) model_img[i] = 8'd0;
        model_new = 0;
        check("rst_mid_ctrl", 32'({AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP}), 32'd0);
        check("rst_mid_rdata", RDATA, 32'd0);
        check("rst_mid_new_image", 32'(NEW_IMAGE), 32'd0);
        check_image("rst_mid_image");
        tick(); ARESETN = 1; BREADY = 1;
        repeat (3) begin
            tick();
            check("post_reset_no_bvalid", 32'(BVALID), 32'd0);
        end
        axi_write(20, 32'h3C, 4'h1);
        axi_read(20);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
